// File: rtl/RS5_pkg.sv
// Shared RS5 types and constants consumed by the execute-stage divider.
package RS5_pkg;

    typedef enum logic [3:0] {
        NOP  = 4'd0,
        ADD  = 4'd1,
        SUB  = 4'd2,
        MUL  = 4'd3,
        DIV  = 4'd4,
        DIVU = 4'd5,
        REM  = 4'd6,
        REMU = 4'd7
    } iType_e;

    typedef enum logic [1:0] {
        D_IDLE = 2'd0,
        D_INIT = 2'd1,
        D_CALC = 2'd2,
        D_SIGN = 2'd3
    } div_states_e;

    localparam logic [31:0] DIV_BY_ZERO_Q = 32'hFFFFFFFF;
    localparam logic [31:0] INT_MIN       = 32'h80000000;

    function automatic logic is_div_op(input iType_e op);
        return (op == DIV) || (op == DIVU) || (op == REM) || (op == REMU);
    endfunction

endpackage

// File: rtl/iterative_divider.sv
// Radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU, one quotient bit per cycle.
// Define DIV_REUSE_EN to add a one-entry result cache for repeated operand pairs.
module iterative_divider
    import RS5_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        start_i,
    input  iType_e      op_i,
    input  logic [31:0] rs1_i,
    input  logic [31:0] rs2_i,
    input  logic        kill_i,
    output logic        busy_o,
    output logic        done_o,
    output logic [31:0] result_o
);

    div_states_e state_q, state_d;
    iType_e      op_q, op_d;
    logic [31:0] op1_q, op1_d;
    logic [31:0] op2_q, op2_d;
    logic [31:0] quo_q, quo_d;
    logic [31:0] rem_q, rem_d;
    logic [31:0] div_q, div_d;
    logic [4:0]  cnt_q, cnt_d;
    logic        neg_quo_q, neg_quo_d;
    logic        neg_rem_q, neg_rem_d;
    logic [31:0] result_q, result_d;
    logic        done_q, done_d;

    logic        signed_op;
    logic        rem_op;
    logic        start_valid;
    logic [31:0] abs1;
    logic [31:0] abs2;
    logic [32:0] partial;
    logic [32:0] trial;
    logic [31:0] quo_fix;
    logic [31:0] rem_fix;
    logic        cache_hit;
    logic [31:0] cache_result;

    assign signed_op   = (op_q == DIV) || (op_q == REM);
    assign rem_op      = (op_q == REM) || (op_q == REMU);
    assign start_valid = start_i && is_div_op(op_i);
    assign abs1        = (signed_op && op1_q[31]) ? -op1_q : op1_q;
    assign abs2        = (signed_op && op2_q[31]) ? -op2_q : op2_q;

    // The extra top bit of the trial difference is the borrow: set means "does not fit".
    assign partial     = {rem_q, quo_q[31]};
    assign trial       = partial - {1'b0, div_q};
    assign quo_fix     = neg_quo_q ? -quo_q : quo_q;
    assign rem_fix     = neg_rem_q ? -rem_q : rem_q;

`ifdef DIV_REUSE_EN
    logic [31:0] c_rs1_q, c_rs1_d;
    logic [31:0] c_rs2_q, c_rs2_d;
    logic [31:0] c_quo_q, c_quo_d;
    logic [31:0] c_rem_q, c_rem_d;
    logic        c_signed_q, c_signed_d;
    logic        c_valid_q, c_valid_d;
    logic        start_signed;

    assign start_signed = (op_i == DIV) || (op_i == REM);
    assign cache_hit    = c_valid_q && (c_rs1_q == rs1_i) && (c_rs2_q == rs2_i)
                          && (c_signed_q == start_signed);
    assign cache_result = ((op_i == REM) || (op_i == REMU)) ? c_rem_q : c_quo_q;

    always_comb begin
        c_rs1_d    = c_rs1_q;
        c_rs2_d    = c_rs2_q;
        c_quo_d    = c_quo_q;
        c_rem_d    = c_rem_q;
        c_signed_d = c_signed_q;
        c_valid_d  = c_valid_q;
        if (kill_i) begin
            c_valid_d = 1'b0;
        end else if (state_q == D_SIGN) begin
            c_rs1_d    = op1_q;
            c_rs2_d    = op2_q;
            c_quo_d    = quo_fix;
            c_rem_d    = rem_fix;
            c_signed_d = signed_op;
            c_valid_d  = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            c_rs1_q    <= '0;
            c_rs2_q    <= '0;
            c_quo_q    <= '0;
            c_rem_q    <= '0;
            c_signed_q <= 1'b0;
            c_valid_q  <= 1'b0;
        end else begin
            c_rs1_q    <= c_rs1_d;
            c_rs2_q    <= c_rs2_d;
            c_quo_q    <= c_quo_d;
            c_rem_q    <= c_rem_d;
            c_signed_q <= c_signed_d;
            c_valid_q  <= c_valid_d;
        end
    end
`else
    assign cache_hit    = 1'b0;
    assign cache_result = '0;
`endif

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        op1_d     = op1_q;
        op2_d     = op2_q;
        quo_d     = quo_q;
        rem_d     = rem_q;
        div_d     = div_q;
        cnt_d     = cnt_q;
        neg_quo_d = neg_quo_q;
        neg_rem_d = neg_rem_q;
        result_d  = result_q;
        done_d    = 1'b0;

        case (state_q)
            D_IDLE: begin
                if (start_valid) begin
                    if (cache_hit) begin
                        result_d = cache_result;
                        done_d   = 1'b1;
                    end else begin
                        op_d    = op_i;
                        op1_d   = rs1_i;
                        op2_d   = rs2_i;
                        state_d = D_INIT;
                    end
                end
            end
            D_INIT: begin
                if (op2_q == '0) begin
                    result_d = rem_op ? op1_q : DIV_BY_ZERO_Q;
                    done_d   = 1'b1;
                    state_d  = D_IDLE;
                end else if (signed_op && (op1_q == INT_MIN) && (op2_q == '1)) begin
                    result_d = rem_op ? '0 : INT_MIN;
                    done_d   = 1'b1;
                    state_d  = D_IDLE;
                end else begin
                    quo_d     = abs1;
                    div_d     = abs2;
                    rem_d     = '0;
                    neg_quo_d = signed_op && (op1_q[31] ^ op2_q[31]);
                    neg_rem_d = signed_op && op1_q[31];
                    cnt_d     = 5'd31;
                    state_d   = D_CALC;
                end
            end
            D_CALC: begin
                if (!trial[32]) begin
                    rem_d = trial[31:0];
                    quo_d = {quo_q[30:0], 1'b1};
                end else begin
                    rem_d = partial[31:0];
                    quo_d = {quo_q[30:0], 1'b0};
                end
                if (cnt_q == 5'd0) begin
                    state_d = D_SIGN;
                end else begin
                    cnt_d = cnt_q - 5'd1;
                end
            end
            D_SIGN: begin
                result_d = rem_op ? rem_fix : quo_fix;
                done_d   = 1'b1;
                state_d  = D_IDLE;
            end
            default: state_d = D_IDLE;
        endcase

        // A flush wins over everything, including a same-cycle launch.
        if (kill_i) begin
            state_d  = D_IDLE;
            done_d   = 1'b0;
            result_d = result_q;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= D_IDLE;
            op_q      <= NOP;
            op1_q     <= '0;
            op2_q     <= '0;
            quo_q     <= '0;
            rem_q     <= '0;
            div_q     <= '0;
            cnt_q     <= '0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            result_q  <= '0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            op1_q     <= op1_d;
            op2_q     <= op2_d;
            quo_q     <= quo_d;
            rem_q     <= rem_d;
            div_q     <= div_d;
            cnt_q     <= cnt_d;
            neg_quo_q <= neg_quo_d;
            neg_rem_q <= neg_rem_d;
            result_q  <= result_d;
            done_q    <= done_d;
        end
    end

    assign busy_o   = (state_q != D_IDLE);
    assign done_o   = done_q;
    assign result_o = result_q;

endmodule

// File: tb/tb_iterative_divider.sv
// Self-checking bench for iterative_divider; honours DIV_REUSE_EN when the build defines it.
module tb_iterative_divider;
    import RS5_pkg::*;

    logic        clk;
    logic        reset;
    logic        start_i;
    iType_e      op_i;
    logic [31:0] rs1_i;
    logic [31:0] rs2_i;
    logic        kill_i;
    logic        busy_o;
    logic        done_o;
    logic [31:0] result_o;

`ifdef DIV_REUSE_EN
    localparam int HIT_LAT = 1;
`else
    localparam int HIT_LAT = 35;
`endif

    int          checks = 0;
    int          errors = 0;
    int          cycle_count = 0;
    int          issue_cycle = 0;
    int          busy_seen = 0;

    bit          pend_active = 0;
    int          pend_k = 0;
    int          pend_lat = 0;
    logic [31:0] pend_res = '0;
    logic [31:0] model_res = '0;
    bit          exp_busy;
    bit          exp_done;

`ifdef DIV_REUSE_EN
    bit          cache_valid = 0;
    logic [31:0] cache_a = '0;
    logic [31:0] cache_b = '0;
    bit          cache_signed = 0;
`endif

    iterative_divider dut (
        .clk      (clk),
        .reset    (reset),
        .start_i  (start_i),
        .op_i     (op_i),
        .rs1_i    (rs1_i),
        .rs2_i    (rs2_i),
        .kill_i   (kill_i),
        .busy_o   (busy_o),
        .done_o   (done_o),
        .result_o (result_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h (cycle %0d)", name, actual, expected, cycle_count);
        end
    endtask

    // Architectural RV32M result, written straight from the ISA rules.
    function automatic logic [31:0] model_result_of(input iType_e op, input logic [31:0] a, input logic [31:0] b);
        logic signed [31:0] sa;
        logic signed [31:0] sb;
        sa = a;
        sb = b;
        case (op)
            DIVU:    return (b == 0) ? 32'hFFFFFFFF : a / b;
            REMU:    return (b == 0) ? a : a % b;
            DIV: begin
                if (b == 0) return 32'hFFFFFFFF;
                if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'h80000000;
                return sa / sb;
            end
            REM: begin
                if (b == 0) return a;
                if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'h0;
                return sa % sb;
            end
            default: return 32'h0;
        endcase
    endfunction

    function automatic bit is_signed_op(input iType_e op);
        return (op == DIV) || (op == REM);
    endfunction

    function automatic bit is_special(input iType_e op, input logic [31:0] a, input logic [31:0] b);
        return (b == 0) || (is_signed_op(op) && a == 32'h80000000 && b == 32'hFFFFFFFF);
    endfunction

    function automatic int model_latency_of(input iType_e op, input logic [31:0] a, input logic [31:0] b);
        if (is_special(op, a, b)) return 2;
`ifdef DIV_REUSE_EN
        if (cache_valid && cache_a == a && cache_b == b && cache_signed == is_signed_op(op)) return 1;
`endif
        return 35;
    endfunction

    function automatic void cache_fill(input iType_e op, input logic [31:0] a, input logic [31:0] b);
`ifdef DIV_REUSE_EN
        cache_valid  = 1;
        cache_a      = a;
        cache_b      = b;
        cache_signed = is_signed_op(op);
`endif
    endfunction

    function automatic void cache_clear();
`ifdef DIV_REUSE_EN
        cache_valid = 0;
`endif
    endfunction

    // Per-cycle compare of busy/done/result against the model's pending operation.
    always @(negedge clk) begin
        cycle_count++;
        if (!reset) begin
            exp_busy = 1'b0;
            exp_done = 1'b0;
            if (pend_active) begin
                pend_k++;
                exp_busy = (pend_k < pend_lat);
                exp_done = (pend_k == pend_lat);
                if (exp_done) begin
                    model_res   = pend_res;
                    pend_active = 0;
                end
            end
            if (busy_o) busy_seen++;
            checkOutput("cmp_busy", 32'(busy_o), 32'(exp_busy));
            checkOutput("cmp_done", 32'(done_o), 32'(exp_done));
            checkOutput("cmp_result", result_o, model_res);
        end
    end

    task automatic issue_op(input iType_e op, input logic [31:0] a, input logic [31:0] b, input bit chain);
        if (!chain) begin
            @(negedge clk);
            #1;
        end
        start_i     = 1'b1;
        op_i        = op;
        rs1_i       = a;
        rs2_i       = b;
        pend_res    = model_result_of(op, a, b);
        pend_lat    = model_latency_of(op, a, b);
        pend_k      = 0;
        pend_active = 1;
        busy_seen   = 0;
        issue_cycle = cycle_count;
        if (pend_lat == 35) cache_fill(op, a, b);
        @(posedge clk);
        #1;
        start_i = 1'b0;
        op_i    = NOP;
    endtask

    task automatic await_result(input string name, input logic [31:0] lit_res, input int lit_lat);
        bit seen;
        int lat;
        seen = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            #2;
            if (done_o) begin
                seen = 1;
                break;
            end
        end
        lat = cycle_count - issue_cycle;
        checkOutput({name, "_done_seen"}, 32'(seen), 32'd1);
        checkOutput({name, "_latency"}, lat, lit_lat);
        checkOutput({name, "_busy_cycles"}, busy_seen, (lit_lat > 1) ? lit_lat - 1 : 0);
        checkOutput({name, "_result"}, result_o, lit_res);
    endtask

    task automatic applyStimulus(input iType_e op, input logic [31:0] a, input logic [31:0] b,
                                 input logic [31:0] lit_res, input int lit_lat,
                                 input string name, input bit chain);
        issue_op(op, a, b, chain);
        await_result(name, lit_res, lit_lat);
    endtask

    initial begin
        reset   = 1'b1;
        start_i = 1'b0;
        kill_i  = 1'b0;
        op_i    = NOP;
        rs1_i   = '0;
        rs2_i   = '0;
        repeat (3) @(negedge clk);
        checkOutput("reset_busy", 32'(busy_o), 32'd0);
        checkOutput("reset_done", 32'(done_o), 32'd0);
        checkOutput("reset_result", result_o, 32'd0);
        checkOutput("pin_model_div", model_result_of(DIV, 32'd100, 32'd7), 32'd14);
        checkOutput("pin_model_rem", model_result_of(REM, 32'hFFFFFFF9, 32'd2), 32'hFFFFFFFF);
        checkOutput("pin_model_remneg", model_result_of(REM, 32'hFFFFFF9C, 32'd7), 32'hFFFFFFFE);
        #1;
        reset = 1'b0;

        applyStimulus(DIV,  32'd100,       32'd7,         32'd14,        35, "div_100_7", 0);
        applyStimulus(REM,  32'hFFFFFFF9,  32'd2,         32'hFFFFFFFF,  35, "rem_m7_2_b2b", 1);
        applyStimulus(DIVU, 32'hFFFFFFFF,  32'd2,         32'h7FFFFFFF,  35, "divu_max_2", 0);
        applyStimulus(DIVU, 32'd5,         32'd0,         32'hFFFFFFFF,  2,  "divu_by0", 0);
        applyStimulus(REMU, 32'd5,         32'd0,         32'd5,         2,  "remu_by0", 0);
        applyStimulus(DIV,  32'h80000000,  32'hFFFFFFFF,  32'h80000000,  2,  "div_ovf", 0);
        applyStimulus(REM,  32'h80000000,  32'hFFFFFFFF,  32'h00000000,  2,  "rem_ovf", 0);
        applyStimulus(DIV,  32'hFFFFFF9C,  32'd7,         32'hFFFFFFF2,  35, "div_m100_7", 0);
        applyStimulus(REM,  32'd100,       32'hFFFFFFF9,  32'd2,         35, "rem_100_m7", 0);
        applyStimulus(REM,  32'hFFFFFF9C,  32'd7,         32'hFFFFFFFE,  35, "rem_m100_7", 0);
        applyStimulus(DIV,  32'd100,       32'hFFFFFFF9,  32'hFFFFFFF2,  35, "div_100_m7", 0);
        applyStimulus(DIVU, 32'h80000000,  32'hFFFFFFFF,  32'h00000000,  35, "divu_min_max", 0);
        applyStimulus(REMU, 32'hFFFFFFFF,  32'd16,        32'h0000000F,  35, "remu_max_16", 0);
        applyStimulus(REMU, 32'h80000000,  32'hFFFFFFFF,  32'h80000000,  35, "remu_min_max", 0);
        applyStimulus(DIVU, 32'd7,         32'd100,       32'd0,         35, "divu_small", 0);
        applyStimulus(DIV,  32'h80000000,  32'd2,         32'hC0000000,  35, "div_min_2", 0);
        applyStimulus(REM,  32'hFFFFFFF9,  32'd0,         32'hFFFFFFF9,  2,  "rem_by0_neg", 0);
        applyStimulus(DIV,  32'd0,         32'd5,         32'd0,         35, "div_zero_5", 0);

        // A second launch while busy must be dropped.
        issue_op(DIVU, 32'd1000, 32'd10, 0);
        repeat (5) @(negedge clk);
        #1;
        start_i = 1'b1;
        op_i    = DIV;
        rs1_i   = 32'd1;
        rs2_i   = 32'd1;
        @(posedge clk);
        #1;
        start_i = 1'b0;
        op_i    = NOP;
        await_result("start_while_busy", 32'd100, 35);

        @(negedge clk);
        #1;
        start_i = 1'b1;
        op_i    = ADD;
        rs1_i   = 32'd100;
        rs2_i   = 32'd7;
        @(posedge clk);
        #1;
        start_i = 1'b0;
        op_i    = NOP;
        repeat (3) @(negedge clk);
        #2;
        checkOutput("invalid_op_busy", 32'(busy_o), 32'd0);
        checkOutput("invalid_op_result", result_o, 32'd100);

        @(negedge clk);
        #1;
        start_i = 1'b1;
        kill_i  = 1'b1;
        op_i    = DIV;
        cache_clear();
        @(posedge clk);
        #1;
        start_i = 1'b0;
        kill_i  = 1'b0;
        op_i    = NOP;
        @(negedge clk);
        #2;
        checkOutput("kill_start_busy", 32'(busy_o), 32'd0);
        checkOutput("kill_start_result", result_o, 32'd100);

        issue_op(DIV, 32'd100, 32'd7, 0);
        repeat (10) @(negedge clk);
        #1;
        kill_i      = 1'b1;
        pend_active = 0;
        cache_clear();
        @(posedge clk);
        #1;
        kill_i = 1'b0;
        @(negedge clk);
        #2;
        checkOutput("kill_busy", 32'(busy_o), 32'd0);
        checkOutput("kill_result", result_o, 32'd100);
        applyStimulus(DIV, 32'd9, 32'd3, 32'd3, 35, "div_after_kill", 1);

        applyStimulus(DIV, 32'd100, 32'd7, 32'd14, 35,      "reuse_fill", 0);
        applyStimulus(REM, 32'd100, 32'd7, 32'd2,  HIT_LAT, "reuse_rem", 0);

        // Asynchronous reset in the middle of a division.
        issue_op(DIV, 32'd50, 32'd5, 0);
        repeat (5) @(negedge clk);
        #1;
        reset       = 1'b1;
        pend_active = 0;
        model_res   = '0;
        cache_clear();
        #1;
        checkOutput("midreset_busy", 32'(busy_o), 32'd0);
        checkOutput("midreset_done", 32'(done_o), 32'd0);
        checkOutput("midreset_result", result_o, 32'd0);
        @(negedge clk);
        #1;
        reset = 1'b0;

        applyStimulus(REM, 32'd100, 32'd7, 32'd2, 35, "rem_after_reset", 0);

        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
